// File: rtl/acc_mem_responder.sv
// -----------------------------------------------------------------------------
// acc_mem_responder
//
// Word-addressed 32-bit memory sitting at the far end of the accelerator bus.
// The accelerator issues one request per cycle (en/we/addr/dataW) and read
// data appears on dataR one cycle later. A secondary valid/ready host port
// loads images and dumps results; it only gets the memory in cycles where
// the accelerator is idle. Out-of-range accesses and accelerator requests
// made while busy set a sticky err flag. Read/write counters saturate.
//
// Optional build macro: MEM_RESP_CLEAR_EN
//   defined   : after reset a CLEAR sweep zero-fills every word, one per
//               cycle, with busy high and both ports blocked.
//   undefined : no sweep, busy tied low, memory undefined until written.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   addr, dataW, en, we accelerator request (word address, write data)
//   dataR               accelerator read data (1-cycle latency, held)
//   h_valid, h_ready    host request handshake
//   h_we, h_addr,
//   h_wdata             host request fields
//   h_rvalid, h_rdata   host read response (one-cycle pulse, data held)
//   busy                clear sweep in progress
//   err                 sticky access error
//   rd_cnt, wr_cnt      serviced accelerator reads / writes (saturating)
// -----------------------------------------------------------------------------
module acc_mem_responder #(
   parameter int DEPTH = 50688,
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      addr,
   input  logic [31:0]      dataW,
   input  logic             en,
   input  logic             we,
   output logic [31:0]      dataR,
   input  logic             h_valid,
   output logic             h_ready,
   input  logic             h_we,
   input  logic [15:0]      h_addr,
   input  logic [31:0]      h_wdata,
   output logic             h_rvalid,
   output logic [31:0]      h_rdata,
   output logic             busy,
   output logic             err,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt
);

   localparam logic [16:0] LP_DEPTH = 17'(DEPTH);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   logic [31:0] r_mem [0:DEPTH-1];

   logic [31:0]      r_dataR;
   logic [31:0]      r_hrdata;
   logic             r_hrvalid;
   logic             r_err;
   logic [CNT_W-1:0] r_rd_cnt;
   logic [CNT_W-1:0] r_wr_cnt;

   logic        w_busy;
   logic        w_clr_we;
   logic [15:0] w_clr_ptr;
   logic        w_acc_in;
   logic        w_h_in;
   logic        w_acc_rd;
   logic        w_acc_wr;
   logic        w_h_acc;
   logic        w_h_rd_acc;
   logic        w_h_wr;
   logic        w_err_set;

`ifdef MEM_RESP_CLEAR_EN
   localparam logic [15:0] LP_LAST = 16'(DEPTH - 1);

   typedef enum logic {ST_CLEAR, ST_READY} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_ptr;
   logic [15:0] w_ptr_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_CLEAR;
         r_ptr   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
      end
   end

   // The edge that zeroes the last word also moves to READY, so busy falls
   // exactly DEPTH cycles after reset release.
   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_clr_we    = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         ST_CLEAR: begin
            w_busy   = 1'b1;
            w_clr_we = 1'b1;
            if (r_ptr == LP_LAST) begin
               w_state_nxt = ST_READY;
               w_ptr_nxt   = '0;
            end else begin
               w_ptr_nxt = r_ptr + 16'd1;
            end
         end
         ST_READY: ;
      endcase
   end

   assign w_clr_ptr = r_ptr;
`else
   assign w_busy    = 1'b0;
   assign w_clr_we  = 1'b0;
   assign w_clr_ptr = '0;
`endif

   assign w_acc_in = ({1'b0, addr}   < LP_DEPTH);
   assign w_h_in   = ({1'b0, h_addr} < LP_DEPTH);

   // Accelerator always wins; host is only granted on idle, non-busy cycles.
   assign h_ready    = ~en & ~w_busy;
   assign w_h_acc    = h_valid & h_ready;
   assign w_h_rd_acc = w_h_acc & ~h_we;
   assign w_h_wr     = w_h_acc & h_we & w_h_in;

   assign w_acc_rd = en & ~we & ~w_busy & w_acc_in;
   assign w_acc_wr = en &  we & ~w_busy & w_acc_in;

   assign w_err_set = (en & (w_busy | ~w_acc_in)) | (w_h_acc & ~w_h_in);

   // Host and accelerator never write in the same cycle, and the sweep runs
   // only while both are blocked, so this is a single write port.
   always_ff @(posedge clk) begin
      if (w_acc_wr) begin
         r_mem[addr] <= dataW;
      end else if (w_h_wr) begin
         r_mem[h_addr] <= h_wdata;
      end else if (w_clr_we) begin
         r_mem[w_clr_ptr] <= '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dataR   <= '0;
         r_hrdata  <= '0;
         r_hrvalid <= 1'b0;
         r_err     <= 1'b0;
         r_rd_cnt  <= '0;
         r_wr_cnt  <= '0;
      end else begin
         r_hrvalid <= w_h_rd_acc;
         // Every attempted accelerator read updates dataR; rejected ones
         // (busy or out of range) return zero.
         if (en & ~we) begin
            r_dataR <= w_acc_rd ? r_mem[addr] : '0;
         end
         if (w_h_rd_acc) begin
            r_hrdata <= w_h_in ? r_mem[h_addr] : '0;
         end
         // Only in-range, non-busy accesses count as serviced.
         if (w_acc_rd) begin
            r_rd_cnt <= sat_inc(r_rd_cnt);
         end
         if (w_acc_wr) begin
            r_wr_cnt <= sat_inc(r_wr_cnt);
         end
         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   assign dataR    = r_dataR;
   assign h_rdata  = r_hrdata;
   assign h_rvalid = r_hrvalid;
   assign busy     = w_busy;
   assign err      = r_err;
   assign rd_cnt   = r_rd_cnt;
   assign wr_cnt   = r_wr_cnt;

endmodule

// File: tb/tb_acc_mem_responder.sv
`timescale 1ns/1ps
module tb_acc_mem_responder;

   localparam int DEPTH = 50688;
   localparam int CNT_W = 24;
   localparam int HALF  = 25344;
`ifdef MEM_RESP_CLEAR_EN
   localparam bit CLR   = 1'b1;
   localparam int N_INV = 2048;
`else
   localparam bit CLR   = 1'b0;
   localparam int N_INV = HALF;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic [15:0]      addr;
   logic [31:0]      dataW;
   logic             en;
   logic             we;
   logic [31:0]      dataR;
   logic             h_valid;
   logic             h_ready;
   logic             h_we;
   logic [15:0]      h_addr;
   logic [31:0]      h_wdata;
   logic             h_rvalid;
   logic [31:0]      h_rdata;
   logic             busy;
   logic             err;
   logic [CNT_W-1:0] rd_cnt;
   logic [CNT_W-1:0] wr_cnt;

   always #5 clk = ~clk;

   acc_mem_responder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .addr(addr), .dataW(dataW), .en(en), .we(we),
      .dataR(dataR), .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we),
      .h_addr(h_addr), .h_wdata(h_wdata), .h_rvalid(h_rvalid),
      .h_rdata(h_rdata), .busy(busy), .err(err), .rd_cnt(rd_cnt),
      .wr_cnt(wr_cnt)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: sparse memory of words written so far plus the
   // expected visible state of the responder.
   logic [31:0] mdl_mem [int];
   logic [31:0] exp_dataR = '0;
   logic [31:0] exp_hrdata = '0;
   logic        exp_err = 1'b0;
   int unsigned exp_rd = 0;
   int unsigned exp_wr = 0;

   function automatic logic [31:0] mdl_read(input int a);
      if (a >= DEPTH) return 32'h0;
      if (mdl_mem.exists(a)) return mdl_mem[a];
      return 32'h0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_dataR"}, dataR, exp_dataR);
      chk({tag, "_err"}, 32'(err), 32'(exp_err));
      chk({tag, "_rd_cnt"}, 32'(rd_cnt), exp_rd);
      chk({tag, "_wr_cnt"}, 32'(wr_cnt), exp_wr);
   endtask

   task automatic acc_read(input int a);
      addr = 16'(a); we = 1'b0; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0;
      if (a < DEPTH) begin
         exp_dataR = mdl_read(a);
         exp_rd++;
      end else begin
         exp_dataR = 32'h0;
         exp_err = 1'b1;
      end
      check_state("acc_rd");
   endtask

   task automatic acc_write(input int a, input logic [31:0] d);
      addr = 16'(a); dataW = d; we = 1'b1; en = 1'b1;
      @(posedge clk); #1;
      en = 1'b0; we = 1'b0;
      if (a < DEPTH) begin
         mdl_mem[a] = d;
         exp_wr++;
      end else begin
         exp_err = 1'b1;
      end
      check_state("acc_wr");
   endtask

   task automatic host_write(input int a, input logic [31:0] d);
      h_addr = 16'(a); h_wdata = d; h_we = 1'b1; h_valid = 1'b1;
      #1;
      chk("hw_ready", 32'(h_ready), 32'd1);
      @(posedge clk); #1;
      h_valid = 1'b0;
      if (a < DEPTH) mdl_mem[a] = d;
      else exp_err = 1'b1;
      chk("hw_rvalid", 32'(h_rvalid), 32'd0);
      chk("hw_err", 32'(err), 32'(exp_err));
   endtask

   task automatic host_read(input int a);
      h_addr = 16'(a); h_we = 1'b0; h_valid = 1'b1;
      #1;
      chk("hr_ready", 32'(h_ready), 32'd1);
      @(posedge clk); #1;
      h_valid = 1'b0;
      exp_hrdata = mdl_read(a);
      if (a >= DEPTH) exp_err = 1'b1;
      chk("hr_rvalid", 32'(h_rvalid), 32'd1);
      chk("hr_rdata", h_rdata, exp_hrdata);
      check_state("hr");
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int bad;
      int a;
      int op;
      int wr_before;
      logic [31:0] d;

      reset = 1'b1; en = 1'b0; we = 1'b0; addr = '0; dataW = '0;
      h_valid = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dataR", dataR, 32'h0);
      chk("rst_h_rdata", h_rdata, 32'h0);
      chk("rst_h_rvalid", 32'(h_rvalid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rd_cnt", 32'(rd_cnt), 32'd0);
      chk("rst_wr_cnt", 32'(wr_cnt), 32'd0);
      chk("rst_busy", 32'(busy), 32'(CLR));
      reset = 1'b0;

`ifdef MEM_RESP_CLEAR_EN
      // Early sweep: everything blocked; an accelerator read is rejected.
      bad = 0;
      for (int c = 0; c < 100; c++) begin
         if (busy !== 1'b1 || h_ready !== 1'b0) bad++;
         if (c == 50) begin addr = 16'd7; we = 1'b0; en = 1'b1; end
         @(posedge clk); #1;
         en = 1'b0;
      end
      chk("sweep1_blocked", 32'(bad), 32'd0);
      chk("busy_rd_err", 32'(err), 32'd1);
      chk("busy_rd_dataR", dataR, 32'h0);
      chk("busy_rd_cnt", 32'(rd_cnt), 32'd0);
      // Reset at cycle 100 restarts a full sweep.
      reset = 1'b1;
      #1;
      chk("rst2_err", 32'(err), 32'd0);
      chk("rst2_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      n = 0; bad = 0;
      while (busy === 1'b1 && n < 60000) begin
         if (h_ready !== 1'b0) bad++;
         @(posedge clk); #1;
         n++;
      end
      chk("sweep_len", 32'(n), 32'(DEPTH));
      chk("sweep_hready", 32'(bad), 32'd0);
      chk("post_sweep_hready", 32'(h_ready), 32'd1);
      mdl_mem.delete();
      acc_read(0);
      acc_read(DEPTH - 1);
      for (int k = 0; k < 6; k++) acc_read(int'($urandom_range(0, DEPTH - 1)));
`endif

      // Host write then accelerator read.
      host_write(5, 32'h11223344);
      acc_read(5);
      chk("tp1_dataR", dataR, 32'h11223344);

      // Write then read-after-write on the next cycle.
      acc_write(25349, 32'hEEDDCCBB);
      acc_read(25349);
      chk("tp2_dataR", dataR, 32'hEEDDCCBB);

      // Host waits while the accelerator holds the bus.
      h_addr = 16'd5; h_we = 1'b0; h_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         addr = 16'd25349; we = 1'b0; en = 1'b1;
         #1;
         chk("prio_hready_low", 32'(h_ready), 32'd0);
         @(posedge clk); #1;
         exp_dataR = mdl_read(25349);
         exp_rd++;
         chk("prio_no_rvalid", 32'(h_rvalid), 32'd0);
         check_state("prio");
      end
      en = 1'b0;
      #1;
      chk("prio_hready_high", 32'(h_ready), 32'd1);
      @(posedge clk); #1;
      h_valid = 1'b0;
      chk("prio_rvalid", 32'(h_rvalid), 32'd1);
      chk("prio_rdata", h_rdata, 32'h11223344);
      check_state("prio_dataR_kept");
      @(posedge clk); #1;
      chk("prio_rvalid_once", 32'(h_rvalid), 32'd0);
      chk("prio_rdata_hold", h_rdata, 32'h11223344);

      // Out-of-range read sets sticky err, then normal read still works.
      acc_read(DEPTH);
      chk("oob_err", 32'(err), 32'd1);
      acc_read(5);
      chk("oob_after_dataR", dataR, 32'h11223344);

      // Randomised mix over a pre-written window plus some out-of-range.
      for (int k = 0; k < 64; k++) host_write(1000 + k, $urandom);
      for (int k = 0; k < 400; k++) begin
         op = int'($urandom_range(0, 3));
         if ($urandom_range(0, 9) == 0) a = int'($urandom_range(DEPTH, 65535));
         else a = 1000 + int'($urandom_range(0, 63));
         d = $urandom;
         case (op)
            0: acc_read(a);
            1: acc_write(a, d);
            2: host_read(a);
            default: host_write(a, d);
         endcase
      end

      // Invert pass: load pattern i, accelerator writes ~word to result half.
      for (int i = 0; i < N_INV; i++) host_write(i, 32'(i));
      wr_before = int'(exp_wr);
      for (int i = 0; i < N_INV; i++) begin
         acc_read(i);
         acc_write(HALF + i, ~dataR);
      end
      chk("inv_wr_cnt", 32'(wr_cnt), 32'(wr_before + N_INV));
      host_read(HALF);
      chk("inv_dump_first", h_rdata, ~32'(0));
      host_read(HALF + N_INV - 1);
      chk("inv_dump_last", h_rdata, ~32'(N_INV - 1));
      for (int k = 0; k < 2046; k++) begin
         a = int'($urandom_range(0, N_INV - 1));
         host_read(HALF + a);
         chk("inv_dump", h_rdata, ~32'(a));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
